// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential execution ALU: function codes
// (mirroring the decoder's ALU_* encoding) and the single-cycle result helper.
package alu_seq_pkg;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    function automatic logic is_shift(input logic [4:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    // SUB arrives as ADD with op2 already negated, so there is no subtract here.
    function automatic logic [31:0] alu_single(input logic [4:0]  sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (sel)
            ALU_ADD:  return a + b;
            ALU_SLT:  return {31'b0, (sa < sb)};
            ALU_SLTU: return {31'b0, (a < b)};
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_LUI:  return {a[19:0], 12'b0};
            default:  return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the multi-cycle shifter: shifts data by a small amount,
// left or right, with zero or sign fill.
module alu_shift_step (
    input  logic [31:0] data,
    input  logic [3:0]  amt,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] shifted
);

    logic signed [31:0] sdata;

    always_comb begin
        sdata = $signed(data);
        if (!dir) begin
            shifted = data << amt;
        end else if (arith) begin
            shifted = sdata >>> amt;
        end else begin
            shifted = data >> amt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential RV32I execution ALU with valid/ready on both sides; logic and
// arithmetic ops take one cycle, shifts iterate SHIFT_STEP bits per cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  alu_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [4:0] STEP_W5 = 5'(SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic [4:0]  rem_q, rem_d;
    logic        dir_q, dir_d;
    logic        arith_q, arith_d;

    logic        accept;
    logic [3:0]  step_amt;
    logic [31:0] step_out;

    // The result register doubles as the shift accumulator while in SHIFT.
    alu_shift_step u_step (
        .data    (result_q),
        .amt     (step_amt),
        .dir     (dir_q),
        .arith   (arith_q),
        .shifted (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= 32'b0;
            zero_q   <= 1'b1;
            rem_q    <= 5'b0;
            dir_q    <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            arith_q  <= arith_d;
        end
    end

    always_comb begin
        if (rem_q < STEP_W5) begin
            step_amt = rem_q[3:0];
        end else begin
            step_amt = STEP_W5[3:0];
        end
    end

    always_comb begin
        result_d = result_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        arith_d  = arith_q;
        if (accept) begin
            dir_d   = (alu_sel != ALU_SLL);
            arith_d = (alu_sel == ALU_SRA);
            if (is_shift(alu_sel)) begin
                result_d = op1;
                rem_d    = op2[4:0];
            end else begin
                result_d = alu_single(alu_sel, op1, op2);
                rem_d    = 5'b0;
            end
        end else if (state_q == ST_SHIFT) begin
            result_d = step_out;
            rem_d    = rem_q - {1'b0, step_amt};
        end
        zero_d = (result_d == 32'b0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (is_shift(alu_sel) && (op2[4:0] != 5'b0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rem_d == 5'b0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted so nothing is accepted then.
    always_comb begin
        in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        accept    = in_valid && in_ready;
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: two instances (SHIFT_STEP 1 and 4) driven
// one at a time with directed vectors; a monitor checks latency and results.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] op1       [2];
    logic [31:0] op2       [2];
    logic [4:0]  alu_sel   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic        zero      [2];

    always #5 clk = ~clk;

    alu_seq #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op1(op1[0]), .op2(op2[0]), .alu_sel(alu_sel[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .zero(zero[0])
    );

    alu_seq #(.SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op1(op1[1]), .op2(op2[1]), .alu_sel(alu_sel[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .zero(zero[1])
    );

    typedef struct {
        int          dut;
        logic [31:0] res;
        logic        z;
        int          exp_cyc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    bit   lat_done [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: checks first-valid latency once per item, result/zero every valid
    // cycle (so held values are verified under backpressure), pops on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && out_valid[d]) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    chk("unexpected_valid", {31'b0, out_valid[d]}, 32'd0);
                end else begin
                    if (!lat_done[d]) begin
                        chk({sb[0].nm, "_latency"}, 32'(cyc), 32'(sb[0].exp_cyc));
                        lat_done[d] = 1'b1;
                    end
                    chk({sb[0].nm, "_result"}, result[d], sb[0].res);
                    chk({sb[0].nm, "_zero"}, {31'b0, zero[d]}, {31'b0, sb[0].z});
                    if (out_ready[d]) begin
                        void'(sb.pop_front());
                        lat_done[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int d, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int lat,
                         input string nm, input bit push);
        int n;
        n = 0;
        in_valid[d] = 1'b1;
        alu_sel[d]  = sel;
        op1[d]      = a;
        op2[d]      = b;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[d] && n < 200);
        if (!in_ready[d]) begin
            chk({nm, "_accept_timeout"}, {31'b0, in_ready[d]}, 32'd1);
            in_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{dut: d, res: er, z: (er == 32'b0), exp_cyc: cyc + lat - 1, nm: nm});
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            op1[d]       = 32'b0;
            op2[d]       = 32'b0;
            alu_sel[d]   = ALU_NONE;
            out_ready[d] = 1'b1;
            lat_done[d]  = 1'b0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("rst_result", result[0], 32'd0);
        chk("rst_zero", {31'b0, zero[0]}, 32'd1);
        chk("rst_in_ready", {31'b0, in_ready[0]}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready_dut1", {31'b0, in_ready[0]}, 32'd1);
        chk("idle_in_ready_dut4", {31'b0, in_ready[1]}, 32'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops, issued back to back.
        issue(0, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "add_wrap", 1);
        issue(0, ALU_ADD,  32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1, "sub_5_5", 1);
        issue(0, ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, "slt", 1);
        issue(0, ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1, "sltu", 1);
        issue(0, ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1, "or", 1);
        issue(0, ALU_AND,  32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 1, "and", 1);
        issue(0, ALU_LUI,  32'h000A_BCDE, 32'h0000_0000, 32'hABCD_E000, 1, "lui", 1);
        issue(0, ALU_NONE, 32'h000A_BCDE, 32'h1234_5678, 32'h0000_0000, 1, "none", 1);
        issue(0, 5'd31,    32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1, "undef", 1);
        drain();

        // Shifts with one bit per cycle.
        issue(0, ALU_SRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32, "sra31_s1", 1);
        drain();
        issue(0, ALU_SLL, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 5, "sll4_s1", 1);
        issue(0, ALU_SRL, 32'h8000_0000, 32'h0000_0025, 32'h0400_0000, 6, "srl5_hi_ignored", 1);
        issue(0, ALU_SLL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1, "shift_amt0", 1);
        drain();

        // Backpressure: result held five cycles, then handoff with no bubble.
        out_ready[0] = 1'b0;
        issue(0, ALU_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1, "add_bp", 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        issue(0, ALU_XOR, 32'h0000_0006, 32'h0000_0006, 32'h0000_0000, 1, "xor_after_bp", 1);
        drain();

        // Reset in the middle of a long shift discards it.
        issue(0, ALU_SLL, 32'h0000_0001, 32'h0000_001F, 32'h0, 0, "sll_reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("midrst_result", result[0], 32'd0);
        chk("midrst_zero", {31'b0, zero[0]}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready[0]}, 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // Shifts with four bits per cycle.
        issue(1, ALU_SRL, 32'h8000_0000, 32'h0000_0005, 32'h0400_0000, 3, "srl5_s4", 1);
        drain();
        issue(1, ALU_SRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 9, "sra31_s4", 1);
        issue(1, ALU_SLL, 32'h0000_0003, 32'h0000_0008, 32'h0000_0300, 3, "sll8_s4", 1);
        issue(1, ALU_SLL, 32'h0000_000F, 32'h0000_0002, 32'h0000_003C, 2, "sll2_s4", 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
